// File: rtl/rotate_shadow_ctrl.sv
// Frame-synchronous shadow register for the YUV420 rotate datapath settings.
// Staged cfg values are committed only between frames, with a one-cycle shadow_sync strobe.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 1
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 2
`endif

module rotate_shadow_ctrl #(
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int ANGLE_WIDTH   = 16
) (
  input  logic                    img_clk,
  input  logic                    resetb,
  input  logic                    cfg_enable_420,
  input  logic                    cfg_enable_rotate,
  input  logic [ANGLE_WIDTH-1:0]  cfg_sin_theta,
  input  logic [ANGLE_WIDTH-1:0]  cfg_cos_theta,
  input  logic                    cfg_update,
  input  logic                    dvi,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic                    dvo,
  input  logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic                    enable_420,
  output logic                    enable_rotate,
  output logic [ANGLE_WIDTH-1:0]  sin_theta,
  output logic [ANGLE_WIDTH-1:0]  cos_theta,
  output logic                    shadow_sync,
  output logic                    pending,
  output logic                    timeout_err,
  output logic [7:0]              commit_count
);

  localparam int DW = `DTYPE_WIDTH;
  localparam int CW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [DW-1:0] DT_FS = DW'(`DTYPE_FRAME_START);
  localparam logic [DW-1:0] DT_FE = DW'(`DTYPE_FRAME_END);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_SYNC} state_t;

  state_t                 r_state;
  logic                   r_in_frame;
  logic                   r_out_frame;
  logic [CW-1:0]          r_drain_cnt;
  logic                   r_pend_420;
  logic                   r_pend_rotate;
  logic [ANGLE_WIDTH-1:0] r_pend_sin;
  logic [ANGLE_WIDTH-1:0] r_pend_cos;

  logic w_busy;
  logic w_drain_expire;

  assign w_busy         = r_in_frame | r_out_frame;
  assign w_drain_expire = (r_state == S_DRAIN) && w_busy && (r_drain_cnt == DRAIN_LAST);

  // A drain timeout abandons both frames so the next update does not stall again.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      r_in_frame  <= 1'b0;
      r_out_frame <= 1'b0;
    end else if (w_drain_expire) begin
      r_in_frame  <= 1'b0;
      r_out_frame <= 1'b0;
    end else begin
      if (dvi && dtypei == DT_FE)      r_in_frame <= 1'b0;
      else if (dvi && dtypei == DT_FS) r_in_frame <= 1'b1;
      if (dvo && dtypeo == DT_FE)      r_out_frame <= 1'b0;
      else if (dvo && dtypeo == DT_FS) r_out_frame <= 1'b1;
    end
  end

  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      r_state       <= S_IDLE;
      r_drain_cnt   <= '0;
      r_pend_420    <= 1'b0;
      r_pend_rotate <= 1'b0;
      r_pend_sin    <= '0;
      r_pend_cos    <= '0;
      pending       <= 1'b0;
      enable_420    <= 1'b0;
      enable_rotate <= 1'b0;
      sin_theta     <= '0;
      cos_theta     <= '0;
      shadow_sync   <= 1'b0;
      timeout_err   <= 1'b0;
      commit_count  <= '0;
    end else begin
      shadow_sync <= 1'b0;
      if (cfg_update) begin
        r_pend_420    <= cfg_enable_420;
        r_pend_rotate <= cfg_enable_rotate;
        r_pend_sin    <= cfg_sin_theta;
        r_pend_cos    <= cfg_cos_theta;
        pending       <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (pending) begin
            r_drain_cnt <= '0;
            r_state     <= w_busy ? S_DRAIN : S_SYNC;
          end
        end
        S_DRAIN: begin
          if (!w_busy) begin
            r_state <= S_SYNC;
          end else if (w_drain_expire) begin
            timeout_err <= 1'b1;
            r_state     <= S_SYNC;
          end else begin
            r_drain_cnt <= r_drain_cnt + CW'(1);
          end
        end
        S_SYNC: begin
          enable_420    <= r_pend_420;
          enable_rotate <= r_pend_rotate;
          sin_theta     <= r_pend_sin;
          cos_theta     <= r_pend_cos;
          shadow_sync   <= 1'b1;
          commit_count  <= commit_count + 8'd1;
          // An update landing on the commit edge stays pending for the next pass.
          if (!cfg_update) pending <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
